// File: rtl/stack_control_unit.sv
// Multicycle control FSM for the stack datapath: sequences FETCH/DECODE/EXEC
// and the optional MEM/WB cycle, decoding every control line from state plus opcode.
module stack_control_unit #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [15:0]     IROut,
    input  logic            isZero,
    output logic            MSPWrite,
    output logic            MSPop,
    output logic            RSPWrite,
    output logic            RSPop,
    output logic            PCWrite,
    output logic            PCSource,
    output logic            PCAdd,
    output logic            ValAWrite,
    output logic            ValBWrite,
    output logic            IRWrite,
    output logic            MemRead1,
    output logic            MemRead2,
    output logic            MemWrite1,
    output logic            MemWrite2,
    output logic            ResSource,
    output logic            ResWrite,
    output logic [1:0]      MemDst1,
    output logic [1:0]      MemDst2,
    output logic [2:0]      MemData,
    output logic [3:0]      ALUop,
    output logic            Halted,
    output logic [CNTW-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD   = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_OR    = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_PUSHI = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_POP   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_STORE = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_BZ    = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_CALL  = OPW'(4'hA);
    localparam logic [OPW-1:0] OP_RET   = OPW'(4'hB);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);

    state_t         state;
    state_t         stateNext;
    logic           retire;
    logic           countInc;
    logic [OPW-1:0] opcode;
    logic           unusedIrBits;

    assign opcode       = IROut[15 -: OPW];
    assign unusedIrBits = ^IROut[15-OPW:0];

    always_comb begin
        stateNext = state;
        retire    = 1'b0;
        case (state)
            S_RST:    stateNext = S_FETCH;
            S_FETCH:  stateNext = S_DECODE;
            S_DECODE: stateNext = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: stateNext = S_WB;
                    OP_RET:  stateNext = S_MEM;
                    OP_HALT: stateNext = S_HALT;
                    default: begin
                        stateNext = S_FETCH;
                        retire    = 1'b1;
                    end
                endcase
            end
            S_MEM, S_WB: begin
                stateNext = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT:   stateNext = S_HALT;
            default:  stateNext = S_RST;
        endcase
    end

    // HALT counts as retired on entry, then the counter freezes
    assign countInc = retire || (state == S_EXEC && opcode == OP_HALT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_RST;
            InstrCount <= '0;
        end else begin
            state <= stateNext;
            if (countInc)
                InstrCount <= InstrCount + 1'b1;
        end
    end

    always_comb begin
        MSPWrite  = 1'b0;
        MSPop     = 1'b0;
        RSPWrite  = 1'b0;
        RSPop     = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        PCAdd     = 1'b0;
        ValAWrite = 1'b0;
        ValBWrite = 1'b0;
        IRWrite   = 1'b0;
        MemRead1  = 1'b0;
        MemRead2  = 1'b0;
        MemWrite1 = 1'b0;
        MemWrite2 = 1'b0;
        ResSource = 1'b0;
        ResWrite  = 1'b0;
        MemDst1   = 2'd0;
        MemDst2   = 2'd0;
        MemData   = 3'd0;
        ALUop     = 4'd0;
        Halted    = 1'b0;
        // Reset overrides the decode combinationally, whatever the state
        if (!RESET) begin
            case (state)
                S_FETCH: begin
                    MemRead1 = 1'b1;
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    PCAdd    = 1'b1;
                end
                S_DECODE: begin
                    MemRead1  = 1'b1;
                    MemDst1   = 2'd1;
                    ValAWrite = 1'b1;
                    MemRead2  = 1'b1;
                    MemDst2   = 2'd1;
                    ValBWrite = 1'b1;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            ALUop    = 4'(opcode);
                            ResWrite = 1'b1;
                        end
                        OP_PUSHI: begin
                            MemWrite1 = 1'b1;
                            MemDst1   = 2'd1;
                            MemData   = 3'd3;
                            MSPWrite  = 1'b1;
                        end
                        OP_POP: begin
                            MSPWrite = 1'b1;
                            MSPop    = 1'b1;
                        end
                        OP_LOAD: begin
                            MemRead1  = 1'b1;
                            MemDst1   = 2'd3;
                            ResWrite  = 1'b1;
                            ResSource = 1'b1;
                        end
                        OP_STORE: begin
                            MemWrite1 = 1'b1;
                            MemDst1   = 2'd3;
                            MSPWrite  = 1'b1;
                            MSPop     = 1'b1;
                        end
                        OP_JUMP: begin
                            PCWrite  = 1'b1;
                            PCSource = 1'b1;
                        end
                        OP_BZ: begin
                            ALUop    = 4'd4;
                            PCWrite  = isZero;
                            PCSource = isZero;
                            MSPWrite = 1'b1;
                            MSPop    = 1'b1;
                        end
                        OP_CALL: begin
                            MemWrite2 = 1'b1;
                            MemDst2   = 2'd2;
                            MemData   = 3'd2;
                            RSPWrite  = 1'b1;
                            PCWrite   = 1'b1;
                            PCSource  = 1'b1;
                        end
                        OP_RET: begin
                            MemRead1 = 1'b1;
                            MemDst1  = 2'd2;
                            RSPWrite = 1'b1;
                            RSPop    = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    MemWrite1 = 1'b1;
                    MemDst1   = 2'd1;
                    MemData   = 3'd1;
                    if (opcode != OP_LOAD) begin
                        MSPWrite = 1'b1;
                        MSPop    = 1'b1;
                    end
                end
                S_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
